// File: rtl/mod4_pkg.sv
// Package: mod4_pkg
// Shared constants and types for the mod4 saturating accumulator stage.
//   DATA_W      : width of the Q2.14 / unsigned sample stream
//   Q_MAX/Q_MIN : signed Q2.14 saturation limits
//   U_MAX       : unsigned saturation limit
//   acc_state_t : frame FSM states
package mod4_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;
  localparam logic [DATA_W-1:0] U_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mod4_sat16.sv
// Module: mod4_sat16
// Combinational clamp for one 16-bit sample coming out of the mod4 adder.
// Ports:
//   data     in  16  raw adder sum
//   overflow in  1   adder overflow flag for data
//   sign     in  1   1 = signed Q2.14, 0 = unsigned
//   data_out out 16  clamped sample
//   clamped  out 1   high when data_out was replaced by a limit
module mod4_sat16
  import mod4_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              overflow,
  input  logic              sign,
  output logic [DATA_W-1:0] data_out,
  output logic              clamped
);

  always_comb begin
    data_out = data;
    clamped  = 1'b0;
    if (overflow) begin
      clamped = 1'b1;
      if (sign) begin
        // A signed overflow wraps to the opposite sign: a negative-looking
        // result came from two positives, so clamp to the positive limit.
        data_out = data[DATA_W-1] ? Q_MAX : Q_MIN;
      end else begin
        data_out = U_MAX;
      end
    end
  end

endmodule

// File: rtl/mod4_sat_accum.sv
// Module: mod4_sat_accum
// Clamps the mod4 adder sum stream and accumulates NUM_ACC samples per frame
// into a widened sum, emitting one result per frame with a clamp count.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   s_tdata/s_overflow    input sample and its overflow flag
//   s_tvalid/s_tready     input handshake
//   sign                  1 = signed Q2.14, latched on the first beat of a frame
//   flush                 close the current frame early (ignored in IDLE/OUTPUT)
//   m_tdata               frame sum, ACC_W bits, sign/zero-extended per frame mode
//   m_count/m_sat_count   samples in frame / clamped samples in frame
//   m_tvalid/m_tready     output handshake
//   dbg_state             current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and not accepted;
// valid never waits on ready. m_* are held stable throughout OUTPUT.
module mod4_sat_accum
  import mod4_pkg::*;
#(
  parameter  int NUM_ACC = 8,
  localparam int ACC_W   = DATA_W + $clog2(NUM_ACC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_overflow,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              sign,
  input  logic              flush,
  output logic [ACC_W-1:0]  m_tdata,
  output logic [8:0]        m_count,
  output logic [8:0]        m_sat_count,
  output logic              m_tvalid,
  input  logic              m_tready,
  output acc_state_t        dbg_state
);

  localparam int         EXT_W     = ACC_W - DATA_W;
  localparam logic [8:0] NUM_ACC_C = 9'(NUM_ACC);

  acc_state_t        state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [8:0]        cnt, cnt_n;
  logic [8:0]        sat, sat_n;
  logic              sign_q, sign_n;
  logic              ready_q;

  logic              beat;
  logic              sgn_use;
  logic [DATA_W-1:0] clamp_data;
  logic              clamped;
  logic [ACC_W-1:0]  ext;
  logic [8:0]        sat_inc;

  // The first beat of a frame uses the live sign input; later beats use the
  // value latched with that first beat, so mid-frame sign changes are ignored.
  assign sgn_use = (state == IDLE) ? sign : sign_q;

  mod4_sat16 u_sat (
    .data     (s_tdata),
    .overflow (s_overflow),
    .sign     (sgn_use),
    .data_out (clamp_data),
    .clamped  (clamped)
  );

  assign ext     = {{EXT_W{sgn_use & clamp_data[DATA_W-1]}}, clamp_data};
  assign sat_inc = {8'd0, clamped};

  // ready_q keeps s_tready low until the first edge after reset release.
  assign s_tready    = ready_q && (state != OUTPUT);
  assign beat        = s_tvalid && s_tready;
  assign m_tvalid    = (state == OUTPUT);
  assign m_tdata     = acc;
  assign m_count     = cnt;
  assign m_sat_count = sat;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sat     <= '0;
      sign_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      sat     <= sat_n;
      sign_q  <= sign_n;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    sat_n   = sat;
    sign_n  = sign_q;
    case (state)
      IDLE: begin
        if (beat) begin
          acc_n   = ext;
          cnt_n   = 9'd1;
          sat_n   = sat_inc;
          sign_n  = sign;
          state_n = (cnt_n == NUM_ACC_C) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_n = acc + ext;
          cnt_n = cnt + 9'd1;
          sat_n = sat + sat_inc;
        end
        // ACCUM always holds at least one sample, so flush can close here.
        if ((beat && (cnt_n == NUM_ACC_C)) || flush) begin
          state_n = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_tready) begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          sat_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
